// File: rtl/mm_sched_pkg.sv
// mm_sched_pkg: shared slot-state encoding, default sizing and clog2 helper for the MM slot scheduler.
package mm_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_RUN_A,
    S_WAIT_C,
    S_RUN_C,
    S_DONE
  } slot_state_t;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_NUM_ROUNDS = 43;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mm_slot_scheduler_rr_arbiter.sv
// rr_arbiter: N-way round-robin picker; search starts at ptr, which parks on an unaccepted grant to keep it stable.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = mm_sched_pkg::clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);
  logic [W-1:0]   ptr;
  logic [W-1:0]   off;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign sum = {1'b0, ptr} + {1'b0, off};
  always_comb begin
    gnt_valid = 1'b0;
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) begin
        gnt_valid = 1'b1;
        off = W'(i);
      end
  end
  assign gnt_idx = !gnt_valid ? '0 : sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : W'(sum);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (gnt_valid) ptr <= !adv ? gnt_idx : gnt_idx == W'(N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/mm_slot_scheduler.sv
// mm_slot_scheduler: tracks concurrent Montgomery jobs through NUM_ROUNDS of phase A / phase C and retires them by tag.
module mm_slot_scheduler
  import mm_sched_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int SLOT_W     = clog2(NUM_SLOTS),
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int ROUND_W    = 6,
  parameter int TAG_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_square,
  output logic               issue_a,
  output logic [SLOT_W-1:0]  issue_a_slot,
  output logic [ROUND_W-1:0] issue_a_round,
  input  logic               done_a,
  input  logic [SLOT_W-1:0]  done_a_slot,
  output logic               issue_c,
  output logic [SLOT_W-1:0]  issue_c_slot,
  output logic               issue_c_last,
  input  logic               done_c,
  input  logic [SLOT_W-1:0]  done_c_slot,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [SLOT_W-1:0]  out_slot,
  output logic               out_square,
  output logic               busy,
  output logic               full,
  output logic               err
);
  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS - 1);
  slot_state_t        st     [NUM_SLOTS];
  slot_state_t        st_nxt [NUM_SLOTS];
  logic [ROUND_W-1:0] rnd    [NUM_SLOTS];
  logic [ROUND_W-1:0] rnd_nxt[NUM_SLOTS];
  logic [TAG_W-1:0]   tag_r  [NUM_SLOTS];
  logic               sq_r   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] idle, req_a, req_c, req_o;
  logic [SLOT_W-1:0]  free_idx;
  logic               acc, retire, clash, ok_a, ok_c, bad;
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_vec
    assign idle[i]  = st[i] == S_IDLE;
    assign req_a[i] = st[i] == S_WAIT_A;
    assign req_c[i] = st[i] == S_WAIT_C;
    assign req_o[i] = st[i] == S_DONE;
  end
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (idle[i]) free_idx = SLOT_W'(i);
  end
  rr_arbiter #(.N(NUM_SLOTS), .W(SLOT_W)) u_arb_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .adv(issue_a), .gnt_valid(issue_a), .gnt_idx(issue_a_slot)
  );
  rr_arbiter #(.N(NUM_SLOTS), .W(SLOT_W)) u_arb_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .adv(issue_c), .gnt_valid(issue_c), .gnt_idx(issue_c_slot)
  );
  rr_arbiter #(.N(NUM_SLOTS), .W(SLOT_W)) u_arb_o (
    .clk(clk), .rst_n(rst_n), .req(req_o), .adv(out_ready), .gnt_valid(out_valid), .gnt_idx(out_slot)
  );
  assign acc    = in_valid & in_ready;
  assign retire = out_valid & out_ready;
  // both strobes on one slot can never be legal, so neither is applied
  assign clash  = done_a & done_c & (done_a_slot == done_c_slot);
  assign ok_a   = done_a & ~clash & (st[done_a_slot] == S_RUN_A);
  assign ok_c   = done_c & ~clash & (st[done_c_slot] == S_RUN_C);
  assign bad    = (done_a & ~ok_a) | (done_c & ~ok_c);
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_nxt[i]  = st[i];
      rnd_nxt[i] = rnd[i];
      if (acc && free_idx == SLOT_W'(i)) begin
        st_nxt[i]  = S_WAIT_A;
        rnd_nxt[i] = '0;
      end
      if (issue_a && issue_a_slot == SLOT_W'(i)) st_nxt[i] = S_RUN_A;
      if (issue_c && issue_c_slot == SLOT_W'(i)) st_nxt[i] = S_RUN_C;
      if (ok_a && done_a_slot == SLOT_W'(i)) st_nxt[i] = S_WAIT_C;
      if (ok_c && done_c_slot == SLOT_W'(i)) begin
        st_nxt[i]  = rnd[i] == LAST ? S_DONE : S_WAIT_A;
        rnd_nxt[i] = rnd[i] == LAST ? rnd[i] : rnd[i] + 1'b1;
      end
      if (retire && out_slot == SLOT_W'(i)) st_nxt[i] = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]    <= S_IDLE;
        rnd[i]   <= '0;
        tag_r[i] <= '0;
        sq_r[i]  <= 1'b0;
      end
    end else begin
      err <= err | bad;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]  <= st_nxt[i];
        rnd[i] <= rnd_nxt[i];
        if (acc && free_idx == SLOT_W'(i)) begin
          tag_r[i] <= in_tag;
          sq_r[i]  <= in_square;
        end
      end
    end
  assign issue_a_round = issue_a ? rnd[issue_a_slot] : '0;
  assign issue_c_last  = issue_c && rnd[issue_c_slot] == LAST;
  assign out_tag       = out_valid ? tag_r[out_slot] : '0;
  assign out_square    = out_valid & sq_r[out_slot];
  assign full          = ~|idle;
  assign busy          = ~&idle;
  assign in_ready      = ~full;
endmodule

// File: tb/tb_mm_slot_scheduler.sv
// tb_mm_slot_scheduler: scoreboard bench with an auto-responding phase model for the MM slot scheduler.
module tb_mm_slot_scheduler;
  localparam int NS = 4;
  localparam int NR = 3;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, in_square = 1'b0;
  logic [7:0] in_tag = '0, out_tag;
  logic       issue_a, issue_c, issue_c_last, done_a = 1'b0, done_c = 1'b0;
  logic [1:0] issue_a_slot, issue_c_slot, done_a_slot = '0, done_c_slot = '0, out_slot;
  logic [5:0] issue_a_round;
  logic       out_valid, out_ready = 1'b1, out_square, busy, full, err;
  always #5 clk = ~clk;
  mm_slot_scheduler #(.NUM_SLOTS(NS), .SLOT_W(2), .NUM_ROUNDS(NR), .ROUND_W(6), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_square(in_square), .issue_a(issue_a), .issue_a_slot(issue_a_slot),
    .issue_a_round(issue_a_round), .done_a(done_a), .done_a_slot(done_a_slot),
    .issue_c(issue_c), .issue_c_slot(issue_c_slot), .issue_c_last(issue_c_last),
    .done_c(done_c), .done_c_slot(done_c_slot), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_slot(out_slot), .out_square(out_square), .busy(busy), .full(full),
    .err(err)
  );
  typedef struct {
    logic [1:0] slot;
    logic [7:0] tag;
    logic       sq;
  } job_t;
  job_t       sb[$];
  logic [1:0] a_order[$];
  int         n_chk = 0, n_pass = 0, retired = 0;
  bit         auto_rsp = 1'b1, acc_seen = 1'b0;
  bit         m_busy[NS];
  int         m_round[NS];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic reset_model();
    sb.delete();
    a_order.delete();
    for (int i = 0; i < NS; i++) begin
      m_busy[i]  = 1'b0;
      m_round[i] = 0;
    end
  endtask
  // one clock: model the expected effects of this cycle, take the edge, answer issues one cycle later
  task automatic cycle();
    logic       ia, ic, rt, any, all;
    logic [1:0] sa, sc, rs;
    int         s, f;
    ia = issue_a; sa = issue_a_slot; ic = issue_c; sc = issue_c_slot; rs = out_slot; rt = 1'b0;
    any = 1'b0; all = 1'b1;
    for (int i = 0; i < NS; i++) begin
      any = any | m_busy[i];
      all = all & m_busy[i];
    end
    check("in_ready", in_ready, !all);
    check("busy", busy, any);
    if (ia) begin
      check("a_round", issue_a_round, m_round[sa]);
      a_order.push_back(sa);
    end
    if (ic) begin
      check("c_last", issue_c_last, m_round[sc] == NR - 1);
      m_round[sc]++;
    end
    acc_seen = 1'b0;
    if (in_valid && in_ready) begin
      s = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) s = i;
      if (s < 0) check("accept_when_full", 0, 1);
      else begin
        sb.push_back('{slot: 2'(s), tag: in_tag, sq: in_square});
        m_busy[s]  = 1'b1;
        m_round[s] = 0;
      end
      acc_seen = 1'b1;
    end
    if (out_valid && out_ready) begin
      f = -1;
      foreach (sb[i]) if (sb[i].slot == out_slot) f = i;
      if (f < 0) check("retire_slot_known", 0, 1);
      else begin
        check("ret_tag", out_tag, sb[f].tag);
        check("ret_square", out_square, sb[f].sq);
        check("ret_rounds", m_round[out_slot], NR);
        sb.delete(f);
      end
      rt = 1'b1;
      retired++;
    end
    @(posedge clk);
    #1;
    if (rt) m_busy[rs] = 1'b0;
    done_a      = auto_rsp && ia;
    done_a_slot = auto_rsp ? sa : 2'd0;
    done_c      = auto_rsp && ic;
    done_c_slot = auto_rsp ? sc : 2'd0;
  endtask
  task automatic send(input logic [7:0] t, input logic s, output bit blocked);
    bit ok;
    ok = 1'b0;
    blocked = 1'b0;
    in_valid = 1'b1; in_tag = t; in_square = s;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (!in_ready) begin
        blocked = 1'b1;
        check("full_while_blocked", full, 1);
      end
      cycle();
      ok = acc_seen;
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      cycle();
      ok = sb.size() == 0;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask
  initial begin
    bit         blk;
    int         r0;
    logic [7:0] h_tag;
    logic [1:0] h_slot;
    reset_model();
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_issue", {issue_a, issue_c, out_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single squaring job through all rounds
    r0 = retired;
    send(8'h5A, 1'b1, blk);
    wait_idle();
    check("single_retired", retired - r0, 1);
    check("single_busy", busy, 0);
    check("single_in_ready", in_ready, 1);
    // five requests into four slots; the fifth waits for a retire
    a_order.delete();
    for (int t = 1; t <= 5; t++) begin
      send(8'(t), 1'(t % 2), blk);
      if (t == 5) check("fifth_blocked", blk, 1);
    end
    check("fair_len", a_order.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("fair_order", a_order[i], i);
    wait_idle();
    // back-pressure with two finished jobs
    out_ready = 1'b0;
    send(8'hA1, 1'b0, blk);
    send(8'hA2, 1'b1, blk);
    for (int k = 0; k < 100 && !out_valid; k++) cycle();
    check("bp_valid", out_valid, 1);
    h_tag = out_tag;
    h_slot = out_slot;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_tag", out_tag, h_tag);
      check("bp_hold_slot", out_slot, h_slot);
    end
    out_ready = 1'b1;
    r0 = retired;
    cycle();
    cycle();
    check("bp_two_retires", retired - r0, 2);
    check("bp_drained", out_valid, 0);
    wait_idle();
    check("err_clean", err, 0);
    // strobe on an idle slot
    auto_rsp = 1'b0;
    done_a = 1'b1; done_a_slot = 2'd2;
    cycle();
    check("err_idle_strobe", err, 1);
    check("err_idle_busy", busy, 0);
    #2 rst_n = 1'b0;
    #1 check("err_cleared", err, 0);
    #2 rst_n = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    // clashing strobes on slot 1 while it is in RUN_A
    send(8'h11, 1'b0, blk);
    send(8'h22, 1'b0, blk);
    cycle();
    cycle();
    check("clash_pre_err", err, 0);
    done_a = 1'b1; done_a_slot = 2'd1; done_c = 1'b1; done_c_slot = 2'd1;
    cycle();
    check("clash_err", err, 1);
    check("clash_no_apply", issue_c, 0);
    done_a = 1'b1; done_a_slot = 2'd1;
    cycle();
    check("clash_still_run_a", issue_c, 1);
    check("clash_c_slot", issue_c_slot, 1);
    // asynchronous reset with three slots occupied
    send(8'h33, 1'b0, blk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_full", full, 0);
    check("arst_err", err, 0);
    check("arst_outs", {issue_a, issue_c, out_valid, issue_a_slot, issue_c_slot}, 0);
    done_a = 1'b0; done_c = 1'b0;
    #2 rst_n = 1'b1;
    reset_model();
    auto_rsp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_rst_no_out", out_valid, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
